// File: rtl/pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Pipelined log2 barrel shifter for the datapath shift unit. It implements
// LSL, LSR, ASR and ROR with an ARM-style shifter carry-out, and uses
// valid/ready handshakes on both sides so it can sit between operand fetch
// and the ALU.
//
// The upper shift ranks and the carry-out are evaluated on the incoming
// operand. The lower ranks are evaluated either after an optional mid
// register (REG_MID=1, latency 2) or directly behind the upper ranks
// (REG_MID=0, latency 1). The result register holds its contents while the
// consumer stalls.
//
// Ports
//   CLK       in   1        clock, rising edge
//   RESET     in   1        synchronous, active-high reset
//   InValid   in   1        operand valid
//   InReady   out  1        operand can be accepted this cycle
//   ShIn      in   WIDTH    operand
//   Shamt     in   SHAMT_W  shift amount, 0..WIDTH-1
//   ShType    in   2        00 LSL, 01 LSR, 10 ASR, 11 ROR
//   CarryIn   in   1        carry passed through when Shamt==0
//   OutValid  out  1        result valid
//   OutReady  in   1        consumer accepts result
//   ShOut     out  WIDTH    shifted result
//   CarryOut  out  1        shifter carry-out
// ---------------------------------------------------------------------------
module pipelined_barrel_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int REG_MID = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   ShIn,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic [1:0]         ShType,
  input  logic               CarryIn,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [WIDTH-1:0]   ShOut,
  output logic               CarryOut
);

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shKind_e;

  // Ranks at or above SPLIT run on the incoming operand; ranks below SPLIT
  // run in the lower half of the pipe.
  localparam int SPLIT = SHAMT_W / 2;

  // One rank of the cascade. For ASR the MSB of the partial result is still
  // the original sign bit, because earlier ASR ranks replicate it.
  function automatic logic [WIDTH-1:0] shiftBy(input logic [WIDTH-1:0] data,
                                               input int               amt,
                                               input shKind_e          kind);
    case (kind)
      SH_LSL:  shiftBy = data << amt;
      SH_LSR:  shiftBy = data >> amt;
      SH_ASR:  shiftBy = $signed(data) >>> amt;
      default: shiftBy = (data >> amt) | (data << (WIDTH - amt));
    endcase
  endfunction

  shKind_e inKind;
  assign inKind = shKind_e'(ShType);

  // ---------------- first stage: upper ranks and carry-out ----------------
  logic [WIDTH-1:0]   upperData;
  logic               inCarry;
  logic [SHAMT_W-1:0] lslIdx;
  logic [SHAMT_W-1:0] rIdx;

  always_comb begin
    // NOTE: a default assignment before the loop keeps this purely
    // combinational; a path that leaves it unassigned would infer a latch.
    upperData = ShIn;
    for (int k = SPLIT; k < SHAMT_W; k++) begin
      if (Shamt[k]) upperData = shiftBy(upperData, 1 << k, inKind);
    end
  end

  // WIDTH - Shamt, taken modulo WIDTH (WIDTH is a power of two).
  assign lslIdx = '0 - Shamt;
  assign rIdx   = Shamt - SHAMT_W'(1);

  always_comb begin
    if (Shamt == '0)            inCarry = CarryIn;
    else if (inKind == SH_LSL)  inCarry = ShIn[lslIdx];
    else                        inCarry = ShIn[rIdx];
  end

  // ---------------- lower-stage inputs (mid register or bypass) -----------
  logic               outLoad;
  logic               lowValid;
  logic [WIDTH-1:0]   lowData;
  logic [SPLIT-1:0]   lowShamt;
  shKind_e            lowKind;
  logic               lowCarry;

  // The result register can take a new entry when it is empty or its
  // current entry is being consumed.
  assign outLoad = !OutValid || OutReady;

  generate
    if (REG_MID != 0) begin : gMid
      logic             midValid;
      logic [WIDTH-1:0] midData;
      logic [SPLIT-1:0] midShamt;
      shKind_e          midKind;
      logic             midCarry;

      // The mid stage loads when empty or when its entry moves on.
      assign InReady = !midValid || outLoad;

      always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value of every other register.
        if (RESET)        midValid <= 1'b0;
        else if (InReady) midValid <= InValid;
      end

      // NOTE: the payload carries no reset; it is only observed through the
      // valid bit, which is reset.
      always_ff @(posedge CLK) begin
        if (InValid && InReady) begin
          midData  <= upperData;
          midShamt <= Shamt[SPLIT-1:0];
          midKind  <= inKind;
          midCarry <= inCarry;
        end
      end

      assign lowValid = midValid;
      assign lowData  = midData;
      assign lowShamt = midShamt;
      assign lowKind  = midKind;
      assign lowCarry = midCarry;
    end else begin : gFlat
      assign InReady  = outLoad;
      assign lowValid = InValid;
      assign lowData  = upperData;
      assign lowShamt = Shamt[SPLIT-1:0];
      assign lowKind  = inKind;
      assign lowCarry = inCarry;
    end
  endgenerate

  // ---------------- lower ranks and result register -----------------------
  logic [WIDTH-1:0] lowerData;

  always_comb begin
    lowerData = lowData;
    for (int k = 0; k < SPLIT; k++) begin
      if (lowShamt[k]) lowerData = shiftBy(lowerData, 1 << k, lowKind);
    end
  end

  // Data only updates when a valid entry lands, so a bubble never disturbs
  // the last result and the outputs ignore operands while InValid is low.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OutValid <= 1'b0;
      ShOut    <= '0;
      CarryOut <= 1'b0;
    end else if (outLoad) begin
      OutValid <= lowValid;
      if (lowValid) begin
        ShOut    <= lowerData;
        CarryOut <= lowCarry;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_barrel_shifter
//
// Two instances of the shifter (index 0: REG_MID=0, index 1: REG_MID=1) are
// exercised one after the other. Expected results come from a queue fed by
// the driver at accept time; a negedge monitor compares every released
// result, checks hold-stability under stalls and, when enabled, latency.
// ---------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        inValid  [2];
  logic        inReady  [2];
  logic [31:0] shIn     [2];
  logic [4:0]  shamt    [2];
  logic [1:0]  shType   [2];
  logic        carryIn  [2];
  logic        outValid [2];
  logic        outReady [2];
  logic [31:0] shOut    [2];
  logic        carryOut [2];

  always #5 CLK = ~CLK;

  pipelined_barrel_shifter #(.WIDTH(32), .REG_MID(0)) dut0 (
    .CLK(CLK), .RESET(RESET),
    .InValid(inValid[0]), .InReady(inReady[0]),
    .ShIn(shIn[0]), .Shamt(shamt[0]), .ShType(shType[0]), .CarryIn(carryIn[0]),
    .OutValid(outValid[0]), .OutReady(outReady[0]),
    .ShOut(shOut[0]), .CarryOut(carryOut[0])
  );

  pipelined_barrel_shifter #(.WIDTH(32), .REG_MID(1)) dut1 (
    .CLK(CLK), .RESET(RESET),
    .InValid(inValid[1]), .InReady(inReady[1]),
    .ShIn(shIn[1]), .Shamt(shamt[1]), .ShType(shType[1]), .CarryIn(carryIn[1]),
    .OutValid(outValid[1]), .OutReady(outReady[1]),
    .ShOut(shOut[1]), .CarryOut(carryOut[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        carry;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    int          s;
    int          t;
    logic        cin;
    logic [31:0] y;
    logic        c;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic        latChk    [2];
  logic        consec    [2];
  logic        havePrev  [2];
  int          prevFire  [2];
  logic        stalled   [2];
  logic        headSeen  [2];
  logic [31:0] heldOut   [2];
  logic        heldCarry [2];
  int          acceptCnt [2];
  logic        randDone;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {carry, result}, straight from the shift definitions.
  function automatic logic [32:0] refModel(input logic [31:0] x, input int s,
                                           input int t, input logic cin);
    logic [63:0] w;
    logic [31:0] y;
    logic        c;
    case (t)
      0: y = x << s;
      1: y = x >> s;
      2: y = $signed(x) >>> s;
      default: begin
        w = {x, x} >> s;
        y = w[31:0];
      end
    endcase
    if (s == 0)      c = cin;
    else if (t == 0) c = x[32 - s];
    else             c = x[s - 1];
    return {c, y};
  endfunction

  function automatic void pushExp(input int d, input exp_t e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  function automatic int qSize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t peekExp(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void popExp(input int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  function automatic void clearQ(input int d);
    if (d == 0) q0.delete(); else q1.delete();
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
  end

  // Monitor: all DUT outputs are sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
        if (RESET) begin
          stalled[d]  = 1'b0;
          headSeen[d] = 1'b0;
        end else begin
          if (stalled[d]) begin
            check($sformatf("m%0d_stall_valid", d), 64'(outValid[d]), 64'(1));
            check($sformatf("m%0d_stall_data", d), 64'(shOut[d]), 64'(heldOut[d]));
            check($sformatf("m%0d_stall_carry", d), 64'(carryOut[d]), 64'(heldCarry[d]));
          end
          stalled[d] = 1'b0;
          if (outValid[d]) begin
            if (qSize(d) == 0) begin
              check($sformatf("m%0d_unexpected_out", d), 64'(outValid[d]), 64'(0));
            end else begin
              e = peekExp(d);
              if (!headSeen[d] && latChk[d])
                check($sformatf("m%0d_latency", d), 64'(cyc - e.acc), 64'(d + 1));
              headSeen[d] = 1'b1;
              if (outReady[d]) begin
                check($sformatf("m%0d_data", d), 64'(shOut[d]), 64'(e.data));
                check($sformatf("m%0d_carry", d), 64'(carryOut[d]), 64'(e.carry));
                if (consec[d] && havePrev[d])
                  check($sformatf("m%0d_release_gap", d), 64'(cyc - prevFire[d]), 64'(1));
                havePrev[d] = 1'b1;
                prevFire[d] = cyc;
                popExp(d);
                headSeen[d] = 1'b0;
              end else begin
                stalled[d]   = 1'b1;
                heldOut[d]   = shOut[d];
                heldCarry[d] = carryOut[d];
              end
            end
          end
        end
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the accept edge,
  // with InValid still asserted so a following call streams back-to-back.
  task automatic sendOp(input int d, input logic [31:0] x, input int s, input int t,
                        input logic cin, input logic [31:0] y, input logic c);
    exp_t e;
    int   n;
    shIn[d]    = x;
    shamt[d]   = 5'(s);
    shType[d]  = 2'(t);
    carryIn[d] = cin;
    inValid[d] = 1'b1;
    n = 0;
    forever begin
      @(negedge CLK);
      if (inReady[d]) begin
        e.data  = y;
        e.carry = c;
        e.acc   = cyc;
        pushExp(d, e);
        acceptCnt[d]++;
        break;
      end
      n++;
      if (n >= 500) begin
        check($sformatf("m%0d_accept_timeout", d), 64'(inReady[d]), 64'(1));
        break;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic sendRef(input int d, input logic [31:0] x, input int s,
                         input int t, input logic cin);
    logic [32:0] r;
    r = refModel(x, s, t, cin);
    sendOp(d, x, s, t, cin, r[31:0], r[32]);
  endtask

  task automatic waitDrain(input int d);
    int n;
    n = 0;
    while ((qSize(d) != 0 || outValid[d]) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 500) check($sformatf("m%0d_drain_timeout", d), 64'(qSize(d)), 64'(0));
    @(posedge CLK);
    #1;
  endtask

  task automatic runDirected(input int d);
    latChk[d] = 1'b1;
    foreach (vecs[i])
      sendOp(d, vecs[i].x, vecs[i].s, vecs[i].t, vecs[i].cin, vecs[i].y, vecs[i].c);
    inValid[d] = 1'b0;
    waitDrain(d);
    latChk[d] = 1'b0;
  endtask

  task automatic runBackpressure(input int d);
    outReady[d]  = 1'b0;
    acceptCnt[d] = 0;
    consec[d]    = 1'b1;
    havePrev[d]  = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          sendRef(d, 32'h1111_1111 * (i + 1), 4 * i + 1, i, 1'b0);
        inValid[d] = 1'b0;
      end
      begin
        repeat (5) @(negedge CLK);
        check($sformatf("m%0d_bp_accepts", d), 64'(acceptCnt[d]), 64'(d + 1));
        check($sformatf("m%0d_bp_inready", d), 64'(inReady[d]), 64'(0));
        @(posedge CLK);
        #1;
        outReady[d] = 1'b1;
      end
    join
    waitDrain(d);
    consec[d] = 1'b0;
  endtask

  task automatic runReset(input int d);
    outReady[d] = 1'b0;
    for (int i = 0; i <= d; i++) sendRef(d, 32'hDEAD_BEEF, 3 + i, 1, 1'b1);
    inValid[d]  = 1'b0;
    RESET       = 1'b1;
    outReady[d] = 1'b1;
    clearQ(d);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check($sformatf("m%0d_rst_outvalid", d), 64'(outValid[d]), 64'(0));
    check($sformatf("m%0d_rst_inready", d), 64'(inReady[d]), 64'(1));
    repeat (3) @(negedge CLK);
    check($sformatf("m%0d_rst_no_stale", d), 64'(outValid[d]), 64'(0));
    @(posedge CLK);
    #1;
    latChk[d] = 1'b1;
    sendOp(d, 32'h8000_0000, 4, 2, 1'b0, 32'hF800_0000, 1'b0);
    inValid[d] = 1'b0;
    waitDrain(d);
    latChk[d] = 1'b0;
  endtask

  task automatic runRandom(input int d);
    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          sendRef(d, $urandom, $urandom_range(0, 31), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            inValid[d] = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #1;
          end
        end
        inValid[d] = 1'b0;
        randDone   = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge CLK);
          #1;
          outReady[d] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    outReady[d] = 1'b1;
    waitDrain(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    for (int d = 0; d < 2; d++) begin
      inValid[d]   = 1'b0;
      shIn[d]      = '0;
      shamt[d]     = '0;
      shType[d]    = '0;
      carryIn[d]   = 1'b0;
      outReady[d]  = 1'b1;
      latChk[d]    = 1'b0;
      consec[d]    = 1'b0;
      havePrev[d]  = 1'b0;
      prevFire[d]  = 0;
      stalled[d]   = 1'b0;
      headSeen[d]  = 1'b0;
      heldOut[d]   = '0;
      heldCarry[d] = 1'b0;
      acceptCnt[d] = 0;
    end
    randDone = 1'b0;

    vecs.push_back(vec_t'{32'h8000_0000, 31, 1, 1'b0, 32'h0000_0001, 1'b0});
    vecs.push_back(vec_t'{32'h0000_0003,  1, 1, 1'b0, 32'h0000_0001, 1'b1});
    vecs.push_back(vec_t'{32'h8000_0000,  4, 2, 1'b0, 32'hF800_0000, 1'b0});
    vecs.push_back(vec_t'{32'h7FFF_FFF0,  4, 2, 1'b0, 32'h07FF_FFFF, 1'b0});
    vecs.push_back(vec_t'{32'h1234_5678,  8, 3, 1'b0, 32'h7812_3456, 1'b0});
    vecs.push_back(vec_t'{32'h0000_0001,  1, 3, 1'b0, 32'h8000_0000, 1'b1});
    vecs.push_back(vec_t'{32'hC000_0000,  1, 0, 1'b0, 32'h8000_0000, 1'b1});
    vecs.push_back(vec_t'{32'hA5A5_0F0F,  0, 0, 1'b1, 32'hA5A5_0F0F, 1'b1});
    vecs.push_back(vec_t'{32'hA5A5_0F0F,  0, 1, 1'b1, 32'hA5A5_0F0F, 1'b1});
    vecs.push_back(vec_t'{32'hA5A5_0F0F,  0, 2, 1'b1, 32'hA5A5_0F0F, 1'b1});
    vecs.push_back(vec_t'{32'hA5A5_0F0F,  0, 3, 1'b1, 32'hA5A5_0F0F, 1'b1});
    vecs.push_back(vec_t'{32'hFFFF_FFFF,  0, 0, 1'b0, 32'hFFFF_FFFF, 1'b0});

    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("m%0d_reset_outvalid", d), 64'(outValid[d]), 64'(0));
      check($sformatf("m%0d_reset_shout", d), 64'(shOut[d]), 64'(0));
      check($sformatf("m%0d_reset_carry", d), 64'(carryOut[d]), 64'(0));
      check($sformatf("m%0d_reset_inready", d), 64'(inReady[d]), 64'(1));
    end
    @(posedge CLK);
    #1;

    for (int d = 0; d < 2; d++) begin
      runDirected(d);
      runBackpressure(d);
      runReset(d);
      runRandom(d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
